// File: rtl/beep_arbiter.sv
// Three-source buzzer arbiter: UART/IR/PS2 events each queue one note, played as a tone then a gap.
// Define BEEP_ARB_RR_EN for round-robin arbitration; default build is fixed priority UART > IR > PS2.
module beep_arbiter #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BEEP_CYC = 5_000_000,
  parameter int GAP_CYC  = 1_000_000
) (
  input  logic        CLK_50M,
  input  logic        RST_N,
  input  logic        uart_finish,
  input  logic        ir_finish,
  input  logic        ps2_finish,
  input  logic [7:0]  in_rx_data,
  input  logic [7:0]  in_ir_data,
  input  logic [15:0] in_ps2_data,
  output logic        BEEP,
  output logic [2:0]  grant,
  output logic        busy,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Half period in clocks, round(CLK_FREQ / (2*f)), with f held in centi-hertz.
  function automatic logic [16:0] hp_of(input int idx);
    longint unsigned f;
    longint unsigned cf;
    case (idx)
      0:       f = 64'd26163;
      1:       f = 64'd29366;
      2:       f = 64'd32963;
      3:       f = 64'd34923;
      4:       f = 64'd39200;
      5:       f = 64'd44000;
      6:       f = 64'd49388;
      default: f = 64'd52325;
    endcase
    cf = 64'(CLK_FREQ) * 64'd100;
    return 17'((cf + f) / (64'd2 * f));
  endfunction

  localparam logic [16:0] HP0 = hp_of(0);
  localparam logic [16:0] HP1 = hp_of(1);
  localparam logic [16:0] HP2 = hp_of(2);
  localparam logic [16:0] HP3 = hp_of(3);
  localparam logic [16:0] HP4 = hp_of(4);
  localparam logic [16:0] HP5 = hp_of(5);
  localparam logic [16:0] HP6 = hp_of(6);
  localparam logic [16:0] HP7 = hp_of(7);

  state_t      state;
  logic [2:0]  pend;
  logic [2:0]  note_u, note_i, note_p;
  logic [2:0]  cur_note;
  logic [16:0] hp_cnt;
  logic [16:0] hp;
  logic [31:0] dur_cnt;
  logic [2:0]  fin;
  logic [2:0]  req;
  logic [2:0]  win;
  logic [2:0]  take;
  logic [2:0]  win_note;
  logic        unused_bits;
`ifdef BEEP_ARB_RR_EN
  logic [1:0]  rr_ptr;
`endif

  assign unused_bits = ^{in_rx_data[7:3], in_ir_data[7:3], in_ps2_data[7:3]};
  assign state_dbg   = state;

  // Break codes (F0 prefix) never request a beep.
  assign fin  = {ps2_finish && (in_ps2_data[15:8] != 8'hF0), ir_finish, uart_finish};
  // A pulse arriving while idle is arbitrated in the same cycle it is seen.
  assign req  = pend | fin;
  assign take = (state == IDLE) ? win : 3'b000;

  always_comb begin
    win = 3'b000;
`ifdef BEEP_ARB_RR_EN
    case (rr_ptr)
      2'd1: begin
        if (req[1])      win = 3'b010;
        else if (req[2]) win = 3'b100;
        else if (req[0]) win = 3'b001;
      end
      2'd2: begin
        if (req[2])      win = 3'b100;
        else if (req[0]) win = 3'b001;
        else if (req[1]) win = 3'b010;
      end
      default: begin
        if (req[0])      win = 3'b001;
        else if (req[1]) win = 3'b010;
        else if (req[2]) win = 3'b100;
      end
    endcase
`else
    if (req[0])      win = 3'b001;
    else if (req[1]) win = 3'b010;
    else if (req[2]) win = 3'b100;
`endif
  end

  // A pending source plays its stored note; a fresh pulse plays the incoming one.
  always_comb begin
    win_note = 3'd0;
    case (win)
      3'b001:  win_note = pend[0] ? note_u : in_rx_data[2:0];
      3'b010:  win_note = pend[1] ? note_i : in_ir_data[2:0];
      3'b100:  win_note = pend[2] ? note_p : in_ps2_data[2:0];
      default: win_note = 3'd0;
    endcase
  end

  always_comb begin
    hp = HP0;
    case (cur_note)
      3'd0:    hp = HP0;
      3'd1:    hp = HP1;
      3'd2:    hp = HP2;
      3'd3:    hp = HP3;
      3'd4:    hp = HP4;
      3'd5:    hp = HP5;
      3'd6:    hp = HP6;
      default: hp = HP7;
    endcase
  end

  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      pend     <= 3'b000;
      note_u   <= 3'd0;
      note_i   <= 3'd0;
      note_p   <= 3'd0;
      cur_note <= 3'd0;
      hp_cnt   <= 17'd0;
      dur_cnt  <= 32'd0;
      BEEP     <= 1'b1;
      grant    <= 3'b000;
      busy     <= 1'b0;
`ifdef BEEP_ARB_RR_EN
      rr_ptr   <= 2'd0;
`endif
    end else begin
      grant <= 3'b000;
      // A pulse landing on the granted source keeps it pending with the new note.
      pend  <= (pend | fin) & ~(take & ~(pend & fin));
      if (fin[0]) note_u <= in_rx_data[2:0];
      if (fin[1]) note_i <= in_ir_data[2:0];
      if (fin[2]) note_p <= in_ps2_data[2:0];

      case (state)
        IDLE: begin
          if (|win) begin
            grant    <= win;
            cur_note <= win_note;
            state    <= PLAY;
            busy     <= 1'b1;
            hp_cnt   <= 17'd0;
            dur_cnt  <= 32'd0;
`ifdef BEEP_ARB_RR_EN
            rr_ptr   <= win[0] ? 2'd1 : (win[1] ? 2'd2 : 2'd0);
`endif
          end
        end
        PLAY: begin
          if (dur_cnt == 32'(BEEP_CYC - 1)) begin
            state   <= GAP;
            BEEP    <= 1'b1;
            dur_cnt <= 32'd0;
          end else begin
            dur_cnt <= dur_cnt + 32'd1;
            if (hp_cnt == hp - 17'd1) begin
              BEEP   <= ~BEEP;
              hp_cnt <= 17'd0;
            end else begin
              hp_cnt <= hp_cnt + 17'd1;
            end
          end
        end
        GAP: begin
          if (dur_cnt == 32'(GAP_CYC - 1)) begin
            state   <= IDLE;
            busy    <= 1'b0;
            dur_cnt <= 32'd0;
          end else begin
            dur_cnt <= dur_cnt + 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_beep_arbiter.sv
// Directed bench for beep_arbiter; time base scaled to a 500 kHz clock so tones stay short.
module tb_beep_arbiter;

  localparam int CLK_FREQ = 500_000;
  localparam int BEEP_CYC = 2_000;
  localparam int GAP_CYC  = 100;
  // Half periods at 500 kHz: E4=758, F4=716, A4=568, C5=478.
  localparam int HP_E4 = 758;
  localparam int HP_F4 = 716;
  localparam int HP_A4 = 568;
  localparam int HP_C5 = 478;

  logic        clk;
  logic        rst_n;
  logic        uart_finish, ir_finish, ps2_finish;
  logic [7:0]  in_rx_data, in_ir_data;
  logic [15:0] in_ps2_data;
  logic        beep;
  logic [2:0]  grant;
  logic        busy;
  logic [1:0]  state_dbg;

  int total = 0;
  int bad   = 0;

  beep_arbiter #(
    .CLK_FREQ(CLK_FREQ),
    .BEEP_CYC(BEEP_CYC),
    .GAP_CYC (GAP_CYC)
  ) dut (
    .CLK_50M    (clk),
    .RST_N      (rst_n),
    .uart_finish(uart_finish),
    .ir_finish  (ir_finish),
    .ps2_finish (ps2_finish),
    .in_rx_data (in_rx_data),
    .in_ir_data (in_ir_data),
    .in_ps2_data(in_ps2_data),
    .BEEP       (beep),
    .grant      (grant),
    .busy       (busy),
    .state_dbg  (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic pulse(input logic u, input logic i, input logic p,
                       input logic [7:0] du, input logic [7:0] di, input logic [15:0] dp);
    uart_finish = u;
    ir_finish   = i;
    ps2_finish  = p;
    in_rx_data  = du;
    in_ir_data  = di;
    in_ps2_data = dp;
    tick(1);
    uart_finish = 1'b0;
    ir_finish   = 1'b0;
    ps2_finish  = 1'b0;
  endtask

  task automatic wait_grant(input int max, output logic [2:0] g, output int w);
    g = grant;
    w = 0;
    while (g == 3'b000 && w < max) begin
      tick(1);
      w++;
      g = grant;
    end
  endtask

  // Waits for a grant, then measures the first two BEEP edges and the busy window.
  task automatic run_tone(input string tag, input logic [2:0] exp_g, input int exp_hp, output int w);
    logic [2:0] g;
    int fall, rise, len;
    wait_grant(5000, g, w);
    check({tag, "_grant"}, 32'(g), 32'(exp_g));
    check({tag, "_state"}, 32'(state_dbg), 32'd1);
    fall = 0;
    rise = 0;
    len  = 0;
    while (busy && len < 5000) begin
      tick(1);
      len++;
      if (len == 1) check({tag, "_oneshot"}, 32'(grant), 32'd0);
      if (fall == 0 && !beep) fall = len;
      else if (fall != 0 && rise == 0 && beep) rise = len;
    end
    check({tag, "_fall"}, fall, exp_hp);
    check({tag, "_rise"}, rise, 2 * exp_hp);
    check({tag, "_busylen"}, len, BEEP_CYC + GAP_CYC);
    check({tag, "_idlebeep"}, 32'(beep), 32'd1);
  endtask

  initial begin
    logic [2:0] g;
    int w;
    logic seen;

    rst_n = 1'b1;
    uart_finish = 1'b0;
    ir_finish   = 1'b0;
    ps2_finish  = 1'b0;
    in_rx_data  = 8'h00;
    in_ir_data  = 8'h00;
    in_ps2_data = 16'h0000;
    #1 rst_n = 1'b0;
    tick(2);
    check("rst_beep",  32'(beep),      32'd1);
    check("rst_grant", 32'(grant),     32'd0);
    check("rst_busy",  32'(busy),      32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    rst_n = 1'b1;
    tick(2);

    // single UART request, note 5 (A4)
    pulse(1'b1, 1'b0, 1'b0, 8'h05, 8'h00, 16'h0000);
    check("u_immediate", 32'(grant), 32'd1);
    run_tone("u05", 3'b001, HP_A4, w);

    // three simultaneous requests
    do_reset();
    pulse(1'b1, 1'b1, 1'b1, 8'h05, 8'h03, 16'h0015);
    run_tone("all_u", 3'b001, HP_A4, w);
    run_tone("all_i", 3'b010, HP_F4, w);
    check("all_i_space", w, 1);
    run_tone("all_p", 3'b100, HP_A4, w);
    check("all_p_space", w, 1);

    // PS/2 break code is ignored
    pulse(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 16'hF015);
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (grant != 3'b000 || busy || !beep) seen = 1'b1;
      tick(1);
    end
    check("brk_activity", 32'(seen), 32'd0);
    check("brk_state", 32'(state_dbg), 32'd0);

    // UART repulsed every tone while IR waits
    do_reset();
    pulse(1'b1, 1'b1, 1'b0, 8'h05, 8'h03, 16'h0000);
    wait_grant(5000, g, w);
    check("arb_g1", 32'(g), 32'd1);
    tick(10);
    pulse(1'b1, 1'b0, 1'b0, 8'h05, 8'h00, 16'h0000);
    wait_grant(5000, g, w);
`ifdef BEEP_ARB_RR_EN
    check("arb_g2", 32'(g), 32'd2);
`else
    check("arb_g2", 32'(g), 32'd1);
`endif
    tick(10);
    pulse(1'b1, 1'b0, 1'b0, 8'h05, 8'h00, 16'h0000);
    wait_grant(5000, g, w);
    check("arb_g3", 32'(g), 32'd1);

    // reset in the middle of a tone discards pending work
    do_reset();
    pulse(1'b1, 1'b0, 1'b0, 8'h05, 8'h00, 16'h0000);
    tick(5);
    pulse(1'b0, 1'b1, 1'b0, 8'h00, 8'h03, 16'h0000);
    tick(994);
    check("mid_beep_low", 32'(beep), 32'd0);
    rst_n = 1'b0;
    #1;
    check("arst_beep",  32'(beep),      32'd1);
    check("arst_busy",  32'(busy),      32'd0);
    check("arst_grant", 32'(grant),     32'd0);
    check("arst_state", 32'(state_dbg), 32'd0);
    tick(3);
    rst_n = 1'b1;
    wait_grant(2500, g, w);
    check("arst_nogrant", 32'(g), 32'd0);

    // latest note wins, only one extra grant
    do_reset();
    pulse(1'b1, 1'b0, 1'b0, 8'h05, 8'h00, 16'h0000);
    tick(5);
    pulse(1'b1, 1'b0, 1'b0, 8'h02, 8'h00, 16'h0000);
    tick(5);
    pulse(1'b1, 1'b0, 1'b0, 8'h07, 8'h00, 16'h0000);
    run_tone("late", 3'b001, HP_C5, w);
    wait_grant(2500, g, w);
    check("late_single", 32'(g), 32'd0);

    // pulse on the same edge its pending request is granted
    do_reset();
    pulse(1'b1, 1'b0, 1'b0, 8'h05, 8'h00, 16'h0000);
    tick(5);
    pulse(1'b1, 1'b0, 1'b0, 8'h02, 8'h00, 16'h0000);
    w = 0;
    while (busy && w < 5000) begin
      tick(1);
      w++;
    end
    check("same_idle", 32'(busy), 32'd0);
    pulse(1'b1, 1'b0, 1'b0, 8'h07, 8'h00, 16'h0000);
    run_tone("same_a", 3'b001, HP_E4, w);
    run_tone("same_b", 3'b001, HP_C5, w);
    check("same_b_space", w, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/beep_arbiter.md
BEEP_ARBITER -- requirements
Module: beep_arbiter

Interface
REQ-001 The block SHALL have parameters: CLK_FREQ, default 50_000_000, clock frequency in Hz.
REQ-002 The block SHALL have parameters: BEEP_CYC, default 5_000_000, tone duration in clocks (100 ms).
REQ-003 The block SHALL have parameters: GAP_CYC, default 1_000_000, silent gap after each tone in clocks (20 ms).
REQ-004 The block SHALL have ports: CLK_50M  in  1  sole clock, rising edge.
REQ-005 The block SHALL have ports: RST_N  in  1  asynchronous active-low reset.
REQ-006 The block SHALL have ports: uart_finish  in  1  one-cycle pulse, UART byte received.
REQ-007 The block SHALL have ports: ir_finish  in  1  one-cycle pulse, IR code received.
REQ-008 The block SHALL have ports: ps2_finish  in  1  one-cycle pulse, PS/2 code received.
REQ-009 The block SHALL have ports: in_rx_data  in  8  UART byte, valid with uart_finish.
REQ-010 The block SHALL have ports: in_ir_data  in  8  IR command, valid with ir_finish.
REQ-011 The block SHALL have ports: in_ps2_data  in  16  PS/2 code {prefix,code}, valid with ps2_finish.
REQ-012 The block SHALL have ports: BEEP  out  1  buzzer drive, idle level 1.
REQ-013 The block SHALL have ports: grant  out  3  one-hot one-cycle grant pulse {ps2,ir,uart}.
REQ-014 The block SHALL have ports: busy  out  1  high in PLAY or GAP.

Function
REQ-015 Each source SHALL own a pending flag plus 3-bit note register; a finish pulse sets the flag and captures data[2:0] (PS/2: in_ps2_data[2:0]).
REQ-016 A PS/2 pulse with in_ps2_data[15:8]==8'hF0 (break code) SHALL be ignored.
REQ-017 A finish pulse on an already-pending source SHALL overwrite its note (latest wins); no count of lost requests.
REQ-018 A finish pulse in the same cycle that source is granted SHALL leave it pending with the new note.
REQ-019 FSM states SHALL be IDLE, PLAY, GAP.
REQ-020 IDLE: if any flag pending, SHALL assert grant for the winner for one cycle, clear its flag, load its note, enter PLAY next cycle; else stay IDLE.
REQ-021 PLAY SHALL last exactly BEEP_CYC cycles; BEEP toggles every HP cycles, first toggle (to 0) at HP cycles after PLAY entry.
REQ-022 Half-period HP SHALL be round(CLK_FREQ/(2*f)) for notes 0..7 = C4,D4,E4,F4,G4,A4,B4,C5 (A4: 56818 at 50 MHz); counter 17 bits.
REQ-023 GAP SHALL last exactly GAP_CYC cycles with BEEP=1, then return to IDLE; requests arriving in PLAY/GAP stay pending.
REQ-024 BEEP SHALL be forced to 1 on leaving PLAY regardless of phase.
REQ-025 Grant-to-grant latency for back-to-back requests SHALL be BEEP_CYC+GAP_CYC+1 cycles.

Reset
REQ-026 RST_N low SHALL immediately (asynchronously) force: state IDLE, all pending flags 0, notes 0, counters 0, BEEP=1, grant=0, busy=0, round-robin pointer to UART.
REQ-027 Reset mid-PLAY SHALL abort the tone; requests made before reset SHALL be discarded.

Configuration
REQ-028 With macro BEEP_ARB_RR_EN defined, arbitration SHALL be round-robin: search starts at the source after the last granted, order UART->IR->PS2->UART.
REQ-029 Without BEEP_ARB_RR_EN, arbitration SHALL be fixed priority UART > IR > PS2; pointer logic absent.

Verification (bench BEEP_CYC=200_000, GAP_CYC=10_000)
REQ-030 uart_finish with in_rx_data=8'h05 in IDLE -> grant=3'b001 next edge, BEEP toggles every 56818 cycles, busy high 210_000 cycles.
REQ-031 uart, ir, ps2 pulsed same cycle (ps2 data 16'h0015) -> grants 001, 010, 100 in order, spaced 210_001 cycles.
REQ-032 ps2_finish with in_ps2_data=16'hF015 -> no pending, no grant, BEEP stays 1.
REQ-033 Fixed priority build: uart repulsed during every PLAY while ir pending -> ir starves; RR build -> ir granted second.
REQ-034 RST_N low 1000 cycles into PLAY with ir pending -> BEEP=1, busy=0, no grant after release.
REQ-035 uart pulsed twice during PLAY (notes 2 then 7) -> one later grant, HP=47778 (C5).
